// File: rtl/asp_irq_ctrl.sv
// Interrupt aggregator: NUM_IRQ edge/level sources with mask, W1C sticky capture,
// a deassert hold-off timer and an assertion counter, behind a 64-bit AVMM CSR slave.
module asp_irq_ctrl #(
    parameter int         NUM_IRQ       = 3,
    parameter int         HOLDOFF_WIDTH = 16,
    parameter logic [7:0] VERSION       = 8'h01
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [63:0]        avs_writedata,
    input  logic [7:0]         avs_byteenable,
    output logic [63:0]        avs_readdata,
    output logic               avs_readdatavalid,
    output logic               avs_waitrequest,
    output logic               irq_out,
    output logic [NUM_IRQ-1:0] irq_pending
);
    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_ENABLE  = 3'd1;
    localparam logic [2:0] A_MODE    = 3'd2;
    localparam logic [2:0] A_HOLDOFF = 3'd3;
    localparam logic [2:0] A_COUNT   = 3'd4;
    localparam logic [2:0] A_ID      = 3'd5;

    logic [NUM_IRQ-1:0]       en_q, en_d, mode_q, mode_d, sticky_q, sticky_d;
    logic [NUM_IRQ-1:0]       prev_q, ipend_q, rise, w1c, pend, pend_en;
    logic [HOLDOFF_WIDTH-1:0] hreg_q, hreg_d, hcnt_q, hcnt_d;
    logic [31:0]              count_q, count_d;
    logic [63:0]              bmask, wbits, rd_word, rdata_q, rdata_d;
    logic                     irq_q, req, rvld_q, count_inc, count_clr;
    logic                     wr_status, wr_enable, wr_mode, wr_holdoff, wr_count;
    logic                     unused_wbits;

    always_comb begin
        for (int b = 0; b < 8; b++) begin
            bmask[8*b +: 8] = {8{avs_byteenable[b]}};
        end
    end

    assign wbits        = avs_writedata & bmask;
    assign unused_wbits = ^wbits;

    assign wr_status  = avs_write && (avs_address == A_STATUS);
    assign wr_enable  = avs_write && (avs_address == A_ENABLE);
    assign wr_mode    = avs_write && (avs_address == A_MODE);
    assign wr_holdoff = avs_write && (avs_address == A_HOLDOFF);
    assign wr_count   = avs_write && (avs_address == A_COUNT);

    assign en_d   = wr_enable  ? ((en_q & ~bmask[NUM_IRQ-1:0]) | wbits[NUM_IRQ-1:0]) : en_q;
    assign mode_d = wr_mode    ? ((mode_q & ~bmask[NUM_IRQ-1:0]) | wbits[NUM_IRQ-1:0]) : mode_q;
    assign hreg_d = wr_holdoff ? ((hreg_q & ~bmask[HOLDOFF_WIDTH-1:0]) | wbits[HOLDOFF_WIDTH-1:0])
                               : hreg_q;

    // A rising edge beats a same-cycle W1C; level-mode sources never hold a sticky bit.
    assign rise     = irq_in & ~prev_q;
    assign w1c      = wr_status ? wbits[NUM_IRQ-1:0] : '0;
    assign sticky_d = (rise | (sticky_q & ~w1c)) & mode_q;

    assign pend    = (mode_q & sticky_q) | (~mode_q & irq_in);
    assign pend_en = pend & en_q;
    assign req     = (|pend_en) && (hcnt_q == '0);

    // Hold-off reloads on the falling edge of irq_out, using the value programmed before it.
    always_comb begin
        hcnt_d = hcnt_q;
        if (irq_q && !req) begin
            hcnt_d = hreg_q;
        end else if (hcnt_q != '0) begin
            hcnt_d = hcnt_q - HOLDOFF_WIDTH'(1);
        end
    end

    assign count_inc = !irq_q && req;
    assign count_clr = wr_count && (|avs_byteenable);
    assign count_d   = (count_clr ? 32'd0 : count_q) + 32'(count_inc);

    always_comb begin
        rd_word = '0;
        case (avs_address)
            A_STATUS:  rd_word[NUM_IRQ-1:0]       = pend;
            A_ENABLE:  rd_word[NUM_IRQ-1:0]       = en_q;
            A_MODE:    rd_word[NUM_IRQ-1:0]       = mode_q;
            A_HOLDOFF: rd_word[HOLDOFF_WIDTH-1:0] = hreg_q;
            A_COUNT:   rd_word[31:0]              = count_q;
            A_ID:      rd_word[15:0]              = {VERSION, 8'(NUM_IRQ)};
            default:   rd_word                    = '0;
        endcase
    end

    assign rdata_d = avs_read ? rd_word : rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q     <= '0;
            mode_q   <= '0;
            sticky_q <= '0;
            prev_q   <= '0;
            ipend_q  <= '0;
            hreg_q   <= '0;
            hcnt_q   <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            rvld_q   <= 1'b0;
        end else begin
            en_q     <= en_d;
            mode_q   <= mode_d;
            sticky_q <= sticky_d;
            prev_q   <= irq_in;
            ipend_q  <= pend_en;
            hreg_q   <= hreg_d;
            hcnt_q   <= hcnt_d;
            count_q  <= count_d;
            irq_q    <= req;
            rdata_q  <= rdata_d;
            rvld_q   <= avs_read;
        end
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvld_q;
    assign avs_waitrequest   = 1'b0;
    assign irq_out           = irq_q;
    assign irq_pending       = ipend_q;

endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Bench for asp_irq_ctrl: directed scenarios followed by random traffic, every cycle
// compared against a behavioural model of the interrupt and CSR rules.
module tb_asp_irq_ctrl;
    localparam int N  = 3;
    localparam int HW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  irq_in;
    logic [2:0]    avs_address;
    logic          avs_read, avs_write;
    logic [63:0]   avs_writedata;
    logic [7:0]    avs_byteenable;
    logic [63:0]   avs_readdata;
    logic          avs_readdatavalid, avs_waitrequest, irq_out;
    logic [N-1:0]  irq_pending;

    always #5 clk = ~clk;

    asp_irq_ctrl #(.NUM_IRQ(N), .HOLDOFF_WIDTH(HW), .VERSION(8'h01)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .irq_in           (irq_in),
        .avs_address      (avs_address),
        .avs_read         (avs_read),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_byteenable   (avs_byteenable),
        .avs_readdata     (avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .avs_waitrequest  (avs_waitrequest),
        .irq_out          (irq_out),
        .irq_pending      (irq_pending)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [63:0]  m_en, m_mode, m_hold, m_rdata;
    logic [N-1:0] m_sticky, m_prev, m_ipend, cur_irq;
    logic [31:0]  m_count;
    logic         m_irq, m_rvld;
    int           edges, fall_edge, fall_h;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = '0; m_mode = '0; m_hold = '0; m_rdata = '0;
        m_sticky = '0; m_prev = '0; m_ipend = '0;
        m_count = '0; m_irq = 1'b0; m_rvld = 1'b0;
        fall_edge = -1000000; fall_h = 0;
    endtask

    // One clock: drive at the falling edge, advance the model, compare after the rising edge.
    task automatic step(input logic [N-1:0] irq, input bit rd, input bit wr,
                        input logic [2:0] addr, input logic [63:0] wd, input logic [7:0] be);
        logic [N-1:0] pend;
        logic [63:0]  bm, rv;
        logic         req, rise_o;
        @(negedge clk);
        irq_in = irq; avs_read = rd; avs_write = wr; avs_address = addr;
        avs_writedata = wd; avs_byteenable = be;
        cur_irq = irq;
        for (int i = 0; i < N; i++) pend[i] = m_mode[i] ? m_sticky[i] : irq[i];
        req = ((pend & m_en[N-1:0]) != '0) && (edges >= fall_edge + fall_h);
        case (addr)
            3'd0:    rv = 64'(pend);
            3'd1:    rv = m_en;
            3'd2:    rv = m_mode;
            3'd3:    rv = m_hold;
            3'd4:    rv = 64'(m_count);
            3'd5:    rv = {48'h0, 8'h01, 8'(N)};
            default: rv = '0;
        endcase
        bm = '0;
        for (int b = 0; b < 8; b++) if (be[b]) bm = bm | (64'hFF << (8 * b));
        for (int i = 0; i < N; i++) begin
            if (!m_mode[i])                          m_sticky[i] = 1'b0;
            else if (irq[i] && !m_prev[i])           m_sticky[i] = 1'b1;
            else if (wr && addr == 3'd0 && bm[i] && wd[i]) m_sticky[i] = 1'b0;
        end
        if (m_irq && !req) begin
            fall_edge = edges + 1;
            fall_h    = int'(m_hold);
        end
        rise_o = !m_irq && req;
        if (wr && addr == 3'd4 && be != 8'h00) m_count = rise_o ? 32'd1 : 32'd0;
        else if (rise_o)                        m_count = m_count + 32'd1;
        m_ipend = pend & m_en[N-1:0];
        if (wr && addr == 3'd1) m_en   = ((m_en & ~bm) | (wd & bm)) & ((64'd1 << N) - 1);
        if (wr && addr == 3'd2) m_mode = ((m_mode & ~bm) | (wd & bm)) & ((64'd1 << N) - 1);
        if (wr && addr == 3'd3) m_hold = ((m_hold & ~bm) | (wd & bm)) & ((64'd1 << HW) - 1);
        m_irq  = req;
        m_prev = irq;
        if (rd) m_rdata = rv;
        m_rvld = rd;
        edges++;
        @(posedge clk);
        #1;
        chk("irq_out", 64'(irq_out), 64'(m_irq));
        chk("irq_pending", 64'(irq_pending), 64'(m_ipend));
        chk("readdatavalid", 64'(avs_readdatavalid), 64'(m_rvld));
        chk("readdata", avs_readdata, m_rdata);
    endtask

    task automatic wreg(input logic [2:0] a, input logic [63:0] d, input logic [7:0] be = 8'hFF);
        step(cur_irq, 1'b0, 1'b1, a, d, be);
    endtask

    task automatic rreg(input logic [2:0] a);
        step(cur_irq, 1'b1, 1'b0, a, 64'h0, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) step(cur_irq, 1'b0, 1'b0, 3'd0, 64'h0, 8'h00);
    endtask

    task automatic drive(input logic [N-1:0] irq);
        step(irq, 1'b0, 1'b0, 3'd0, 64'h0, 8'h00);
    endtask

    initial begin
        int low;
        logic [2:0]  ra;
        logic [63:0] rd_val;
        reset_n = 1'b0; irq_in = '0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = '0; cur_irq = '0; edges = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_irq_out", 64'(irq_out), 64'h0);
        chk("reset_irq_pending", 64'(irq_pending), 64'h0);
        chk("reset_readdata", avs_readdata, 64'h0);
        chk("reset_rvld", 64'(avs_readdatavalid), 64'h0);
        chk("waitrequest", 64'(avs_waitrequest), 64'h0);
        reset_n = 1'b1;

        // Post-reset register contents and read latency
        for (int k = 0; k < 6; k++) begin
            rreg(3'(k));
            chk("rd_vld_on", 64'(avs_readdatavalid), 64'h1);
            chk("rd_reset_val", avs_readdata, (k == 5) ? 64'h0103 : 64'h0);
            idle(1);
            chk("rd_vld_off", 64'(avs_readdatavalid), 64'h0);
        end

        // Edge source: single-cycle pulse, then W1C
        wreg(3'd1, 64'h7);
        wreg(3'd2, 64'h1);
        drive(3'b001);
        drive(3'b000);
        chk("edge_irq_rise", 64'(irq_out), 64'h1);
        rreg(3'd0);
        chk("edge_status", avs_readdata, 64'h1);
        wreg(3'd0, 64'h1);
        idle(1);
        chk("edge_irq_cleared", 64'(irq_out), 64'h0);
        rreg(3'd4);
        chk("count_one", avs_readdata, 64'h1);

        // Level source: W1C ignored, follows input, masked by ENABLE
        wreg(3'd2, 64'h0);
        wreg(3'd1, 64'h2);
        drive(3'b010);
        idle(2);
        chk("level_high", 64'(irq_out), 64'h1);
        wreg(3'd0, 64'h2);
        idle(1);
        chk("level_w1c_noeffect", 64'(irq_out), 64'h1);
        drive(3'b000);
        idle(1);
        chk("level_drop", 64'(irq_out), 64'h0);
        drive(3'b010);
        idle(1);
        wreg(3'd1, 64'h0);
        idle(1);
        chk("level_masked", 64'(irq_out), 64'h0);
        drive(3'b000);

        // Hold-off of 10 cycles, re-pended on the falling edge
        wreg(3'd1, 64'h7);
        wreg(3'd2, 64'h7);
        wreg(3'd3, 64'd10);
        drive(3'b001);
        drive(3'b000);
        idle(1);
        wreg(3'd0, 64'h1);
        drive(3'b100);
        chk("holdoff_fall", 64'(irq_out), 64'h0);
        low = 0;
        for (int c = 0; c < 14; c++) begin
            idle(1);
            if (!irq_out) low++;
        end
        chk("holdoff_low_cycles", 64'(low), 64'd10);
        chk("holdoff_reassert", 64'(irq_out), 64'h1);

        // No hold-off: immediate reassertion
        wreg(3'd3, 64'd0);
        wreg(3'd0, 64'h4);
        drive(3'b001);
        idle(1);
        chk("noholdoff_reassert", 64'(irq_out), 64'h1);
        drive(3'b000);

        // Rising edge and W1C on the same bit in the same cycle
        wreg(3'd0, 64'h7);
        step(3'b100, 1'b0, 1'b1, 3'd0, 64'h4, 8'hFF);
        rreg(3'd0);
        chk("collision_set_wins", avs_readdata & 64'h4, 64'h4);

        // COUNT wrap and clear/increment collision
        wreg(3'd0, 64'h7);
        drive(3'b000);
        wreg(3'd1, 64'h0);
        idle(2);
        @(negedge clk);
        force dut.count_d = 32'hFFFF_FFFF;
        idle(1);
        release dut.count_d;
        m_count = 32'hFFFF_FFFF;
        rreg(3'd4);
        chk("count_preload", avs_readdata, 64'hFFFF_FFFF);
        wreg(3'd1, 64'h7);
        drive(3'b001);
        drive(3'b000);
        idle(1);
        rreg(3'd4);
        chk("count_wrap", avs_readdata, 64'h0);
        wreg(3'd0, 64'h1);
        drive(3'b001);
        wreg(3'd4, 64'h0);
        rreg(3'd4);
        chk("count_clear_inc", avs_readdata, 64'h1);
        drive(3'b000);

        // Unimplemented bits, byte enables, reserved addresses
        wreg(3'd0, 64'hFF);
        rreg(3'd0);
        chk("status_hi_zero", avs_readdata >> 3, 64'h0);
        wreg(3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        rreg(3'd1);
        chk("enable_width", avs_readdata, 64'h7);
        wreg(3'd3, 64'h1234_5678_ABCD, 8'h01);
        rreg(3'd3);
        chk("holdoff_byteen", avs_readdata, 64'hCD);
        wreg(3'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        rreg(3'd3);
        chk("holdoff_width", avs_readdata, 64'hFFFF);
        wreg(3'd3, 64'h0);
        wreg(3'd6, 64'hFFFF_FFFF_FFFF_FFFF);
        rreg(3'd6);
        chk("addr6_zero", avs_readdata, 64'h0);
        rreg(3'd7);
        chk("addr7_zero", avs_readdata, 64'h0);

        // Asynchronous reset while irq_out is high
        wreg(3'd2, 64'h0);
        drive(3'b010);
        idle(1);
        chk("pre_reset_high", 64'(irq_out), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_irq", 64'(irq_out), 64'h0);
        chk("async_reset_pend", 64'(irq_pending), 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        // Random traffic against the model
        for (int t = 0; t < 500; t++) begin
            ra     = 3'($urandom_range(0, 7));
            rd_val = {$urandom, $urandom};
            if (ra == 3'd3) rd_val = 64'($urandom_range(0, 6));
            step(N'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 ra, rd_val, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/asp_irq_ctrl.md
Name: asp_irq_ctrl

Overview:
- Parametrised interrupt aggregator for the ASP. It takes NUM_IRQ interrupt sources from the DMA channels, the kernel and I/O pipes, and produces one host interrupt line.
- Each source has a mask bit and a selectable edge/level mode. Edge-mode sources are captured sticky and cleared with write-1-to-clear (W1C).
- A programmable hold-off timer enforces a minimum interrupt-deassert interval, and a counter records how many interrupts have been asserted.
- Sits between the interrupt sources and the FIM interrupt interface. It is controlled through a 64-bit AVMM CSR slave on the ASP MMIO path.

Parameters:
- NUM_IRQ, 3, number of interrupt sources; legal range 1..64.
- HOLDOFF_WIDTH, 16, width of the hold-off reload register and counter, in cycles; legal range 1..32.
- VERSION, 8'h01, block version reported in the ID register.

Ports:
- clk  in  1  block clock; all logic is synchronous to it.
- reset_n  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_IRQ  interrupt sources, synchronous to clk, active-high.
- avs_address  in  3  CSR word address (64-bit words).
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  64  write data.
- avs_byteenable  in  8  per-byte write enables.
- avs_readdata  out  64  read data.
- avs_readdatavalid  out  1  read response valid.
- avs_waitrequest  out  1  tied 0; the slave accepts a command every cycle.
- irq_out  out  1  aggregated host interrupt, registered.
- irq_pending  out  NUM_IRQ  masked pending vector (pending & enable), registered, for debug.

Behaviour:
- Reset: every register and output is 0, including irq_out, irq_pending, avs_readdata, avs_readdatavalid, MASK, MODE, HOLDOFF, COUNT, the sticky pending bits and the irq_in history register.
- CSR map (word address):
  - 0 STATUS: reads the pending vector; a write of 1 clears the sticky bit of an edge-mode source.
  - 1 ENABLE: RW, 1 = source enabled.
  - 2 MODE: RW, 1 = edge, 0 = level.
  - 3 HOLDOFF: RW, lower HOLDOFF_WIDTH bits.
  - 4 COUNT: 32-bit RO counter; any write clears it.
  - 5 ID: RO; [7:0] = NUM_IRQ, [15:8] = VERSION, [63:16] = 0.
  - 6 and 7: read as 0, writes ignored.
- Bit rules: bits at or above NUM_IRQ (or HOLDOFF_WIDTH for HOLDOFF) read 0 and ignore writes.
- Byte enables:
  - RW registers update only the enabled bytes.
  - The STATUS W1C mask is writedata & expanded byteenable.
  - A COUNT clear happens when any byteenable bit is set.
- Read timing:
  - Fixed latency of 1 cycle: avs_readdatavalid pulses the cycle after avs_read.
  - avs_readdata holds its last value when not valid.
  - A read and a write in the same cycle are both performed, and the read returns the pre-write value.
- Edge capture: prev[i] is the registered irq_in[i]. A rising edge (irq_in & ~prev) on an edge-mode source sets sticky[i].
- Level sources: pending[i] = irq_in[i] directly; their sticky[i] is forced to 0.
- Edge sources: pending[i] = sticky[i].
- Set/clear collision: if a rising edge and a W1C on the same bit occur in the same cycle, the set wins and the bit stays 1.
- Mode change:
  - Changing a bit from edge to level discards its sticky bit.
  - Changing from level to edge starts capture on the next rising edge; a level already high is not captured.
- Aggregation:
  - req = |(pending & ENABLE) & (holdoff_cnt == 0).
  - irq_out is the registered req: 1-cycle latency from a pending/enable change to irq_out.
  - irq_pending is the registered (pending & ENABLE), also 1-cycle latency.
- Hold-off:
  - On an irq_out 1->0 transition, holdoff_cnt loads HOLDOFF and then decrements each cycle down to 0.
  - irq_out stays 0 while holdoff_cnt != 0.
  - HOLDOFF = 0 means no suppression.
  - Writing HOLDOFF during a countdown does not affect the running count.
- COUNT:
  - Increments on each irq_out 0->1 transition and wraps at 2^32.
  - If a clear write and an increment occur in the same cycle, the result is 1.
- Reset mid-operation: asynchronous reset clears everything, including sticky bits and the hold-off counter. irq_out drops immediately.

Test Plan:
- Reset, then read addresses 0-5 -> all read 0, except ID = 0x0103 for NUM_IRQ=3. readdatavalid asserts exactly 1 cycle after each read.
- ENABLE=0x7, MODE=0x1; pulse irq_in[0] high for 1 cycle -> STATUS=0x1 and irq_out=1 two cycles after the pulse. Write STATUS=0x1 -> irq_out=0 one cycle later, and COUNT=1.
- MODE=0, ENABLE=0x2; hold irq_in[1] high -> irq_out stays 1. Writing STATUS=0x2 has no effect. Drop irq_in[1] -> irq_out=0 two cycles later. Write ENABLE=0 while irq_in[1] is high -> irq_out clears.
- HOLDOFF=10; toggle an edge source so irq_out falls, then re-pend immediately -> irq_out stays low for 10 cycles after the fall, then reasserts. With HOLDOFF=0 -> it reasserts on the next cycle.
- In the same cycle, send a rising edge on irq_in[2] (edge mode) and a W1C of bit 2 -> STATUS bit 2 reads 1.
- Preload COUNT=0xFFFF_FFFF by forcing it, then cause one interrupt -> COUNT=0. Write to address 4 coinciding with an irq_out rise -> COUNT=1. Write 0xFF to address 0 with NUM_IRQ=3 -> bits 7:3 read back 0.
